// File: rtl/mult_seq_ctrl.sv
// Sequencing FSM for an N-bit shift-and-add multiplier datapath (controller only, no datapath registers).
// Optional MULT_EARLY_TERM_EN: leave the ADD/SHIFT loop as soon as the multiplier register is empty.

module incBy1 #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y,
  output logic         co
);
  assign {co, y} = {1'b0, a} + {{W{1'b0}}, 1'b1};
endmodule

// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; count holds the last result
// LOAD  | load operands, clear product; count cleared at end of cycle
// ADD   | add multiplicand to product when the multiplier LSB is set
// SHIFT | shift both operand registers; count advances
// DONE  | one-cycle completion pulse; count holds iterations completed
module mult_seq_ctrl #(
  parameter int N  = 4,
  parameter int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mplrLsb,
  input  logic          mplrZero,
  output logic          load,
  output logic          addEn,
  output logic          shiftEn,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [CW-1:0] count_inc;
  logic          inc_co;
  logic          early_term;

  incBy1 #(.W(CW)) u_inc (
    .a  (count),
    .y  (count_inc),
    .co (inc_co)
  );

`ifdef MULT_EARLY_TERM_EN
  assign early_term = mplrZero;
  logic unused_sigs;
  assign unused_sigs = inc_co;
`else
  // mplrZero stays on the port list so both builds share one interface.
  assign early_term = 1'b0;
  logic unused_sigs;
  assign unused_sigs = ^{inc_co, mplrZero};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_LOAD;
        S_LOAD: begin
          state <= S_ADD;
          count <= '0;
        end
        S_ADD: state <= early_term ? S_DONE : S_SHIFT;
        S_SHIFT: begin
          count <= count_inc;
          state <= (count == LAST) ? S_DONE : S_ADD;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // addEn is the only output that is not a pure state decode: it follows mplrLsb.
  assign load    = (state == S_LOAD);
  assign addEn   = (state == S_ADD) & mplrLsb & ~early_term;
  assign shiftEn = (state == S_SHIFT);
  assign done    = (state == S_DONE);
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: N=4 and N=8 instances driven by a datapath model and
// checked cycle by cycle against an iteration-level reference trace.
module tb_mult_seq_ctrl;

`ifdef MULT_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] start_i;
  logic [1:0] ld, ae, se, bz, dn;
  logic [2:0] cnt4;
  logic [3:0] cnt8;

  logic [7:0]  a_in   [2];
  logic [7:0]  m_in   [2];
  logic [7:0]  mplr   [2];
  logic [15:0] mcand  [2];
  logic [15:0] prod   [2];
  int          exp_cnt[2];

  int n_chk  = 0;
  int n_pass = 0;

  mult_seq_ctrl #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]),
    .mplrLsb(mplr[0][0]), .mplrZero(mplr[0] == 8'h00),
    .load(ld[0]), .addEn(ae[0]), .shiftEn(se[0]), .busy(bz[0]), .done(dn[0]),
    .count(cnt4)
  );

  mult_seq_ctrl #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]),
    .mplrLsb(mplr[1][0]), .mplrZero(mplr[1] == 8'h00),
    .load(ld[1]), .addEn(ae[1]), .shiftEn(se[1]), .busy(bz[1]), .done(dn[1]),
    .count(cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared multiplicand/multiplier/product registers, driven only by the strobes.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        mplr[d]  <= 8'h00;
        mcand[d] <= 16'h0000;
        prod[d]  <= 16'h0000;
      end else if (ld[d]) begin
        mplr[d]  <= m_in[d];
        mcand[d] <= {8'h00, a_in[d]};
        prod[d]  <= 16'h0000;
      end else begin
        if (ae[d]) prod[d] <= prod[d] + mcand[d];
        if (se[d]) begin
          mcand[d] <= mcand[d] << 1;
          mplr[d]  <= mplr[d] >> 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
  endtask

  function automatic logic [8:0] pack(input bit l, input bit a, input bit s,
                                      input bit d, input bit b, input int c);
    return {l, a, s, d, b, 4'(c)};
  endfunction

  function automatic logic [8:0] obs(input int d);
    if (d == 0) return {ld[0], ae[0], se[0], dn[0], bz[0], 1'b0, cnt4};
    return {ld[1], ae[1], se[1], dn[1], bz[1], cnt8};
  endfunction

  // Iterations one operation performs: all N, or with early exit only up to the top set bit.
  function automatic int iters(input int n, input logic [7:0] m);
    int k;
    if (!ET) return n;
    k = 0;
    for (int i = 0; i < n; i++) if (m[i]) k = i + 1;
    return k;
  endfunction

  // One operation launched by start at edge 0. extra[c] raises start during cycle c;
  // hold keeps start high throughout and expects a relaunch two cycles after DONE.
  task automatic run_op(input int d, input int n, input logic [7:0] a, input logic [7:0] m,
                        input logic [31:0] extra_in, input bit hold, input bit rand_busy,
                        input string tag);
    logic [8:0]  exp_q[$];
    logic [7:0]  mm, aa;
    logic [31:0] extra;
    int          it;
    int          sz;
    mm = m & 8'((1 << n) - 1);
    aa = a & 8'((1 << n) - 1);
    it = iters(n, mm);
    exp_q.push_back(pack(1, 0, 0, 0, 1, exp_cnt[d]));
    for (int i = 0; i < it; i++) begin
      exp_q.push_back(pack(0, mm[i], 0, 0, 1, i));
      exp_q.push_back(pack(0, 0, 1, 0, 1, i));
    end
    if (it < n) exp_q.push_back(pack(0, 0, 0, 0, 1, it));  // ADD that sees an empty multiplier
    exp_q.push_back(pack(0, 0, 0, 1, 1, it));
    exp_q.push_back(pack(0, 0, 0, 0, 0, it));
    if (hold) exp_q.push_back(pack(1, 0, 0, 0, 1, it));
    sz = exp_q.size();
    extra = extra_in;
    if (rand_busy) extra = $urandom & (32'((64'd1 << (sz - 1)) - 1)) & ~32'h3;

    a_in[d] = aa;
    m_in[d] = mm;
    start_i[d] = 1'b1;
    for (int c = 1; c <= sz; c++) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d", tag, c), 32'(obs(d)), 32'(exp_q[c-1]));
      if (exp_q[c-1][5]) chk({tag, "_prod"}, 32'(prod[d]), 32'(16'(aa) * 16'(mm)));
      start_i[d] = hold | ((c + 1 < 32) ? extra[c+1] : 1'b0);
    end
    start_i[d] = 1'b0;
    exp_cnt[d] = it;
  endtask

  // Let an operation already under way finish, with a bounded wait.
  task automatic drain(input int d, input int n, input logic [7:0] m, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 4 * n + 8 && !seen; k++) begin
      @(negedge clk);
      if (obs(d)[5]) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) chk({tag, "_count"}, 32'(obs(d)[3:0]), 32'(iters(n, m & 8'((1 << n) - 1))));
    @(negedge clk);
    exp_cnt[d] = iters(n, m & 8'((1 << n) - 1));
  endtask

  initial begin
    logic [7:0] ra, rm;
    int         rd;
    rst_n   = 1'b0;
    start_i = 2'b00;
    for (int d = 0; d < 2; d++) begin
      a_in[d] = 8'h00;
      m_in[d] = 8'h00;
      exp_cnt[d] = 0;
    end
    repeat (2) @(negedge clk);
    chk("reset_n4", 32'(obs(0)), 32'd0);
    chk("reset_n8", 32'(obs(1)), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 4, 8'h0D, 8'b1011, 32'd0, 1'b0, 1'b0, "basic_n4");
    run_op(0, 4, 8'h07, 8'b0110, (32'd1 << 3) | (32'd1 << 10), 1'b0, 1'b0, "busy_start");
    run_op(0, 4, 8'h09, 8'b1011, 32'd0, 1'b1, 1'b0, "hold_start");
    drain(0, 4, 8'b1011, "hold_drain");

    run_op(1, 8, 8'hC3, 8'hA7, 32'd0, 1'b0, 1'b0, "basic_n8");
    run_op(1, 8, 8'h5B, 8'b00000101, 32'd0, 1'b0, 1'b0, "small_mplr_n8");
    run_op(1, 8, 8'h21, 8'h00, 32'd0, 1'b0, 1'b0, "zero_mplr_n8");
    run_op(1, 8, 8'hFF, 8'hFF, 32'd0, 1'b0, 1'b0, "max_n8");

    // Reset in the middle of an N=4 operation: outputs drop at once, no done.
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_in_shift", 32'(se[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_async", 32'(obs(0)), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_mid_no_done", 32'(obs(0)), 32'd0);
    end
    rst_n = 1'b1;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    @(negedge clk);
    chk("rst_release_idle", 32'(obs(0)), 32'd0);
    run_op(0, 4, 8'h0B, 8'h0E, 32'd0, 1'b0, 1'b0, "after_rst_n4");

    for (int r = 0; r < 10; r++) begin
      rd = int'($urandom_range(0, 1));
      ra = 8'($urandom);
      rm = 8'($urandom);
      if (r == 3) rm = 8'h00;
      run_op(rd, rd ? 8 : 4, ra, rm, 32'd0, 1'b0, 1'b1, $sformatf("rand%0d", r));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
